// File: rtl/instr_mem_sync.sv
// Synchronous-read instruction memory for the IF/ID boundary: registered read
// port with stall/flush, word-write loader and a post-reset NOP-clear sweep.
module instr_mem_sync #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter logic [DATA_WIDTH-1:0] NOP        = 32'h00000013,
    parameter bit                    INIT_CLEAR = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  rd_valid,
    output logic                  misaligned,
    output logic                  out_of_range,
    output logic                  ready,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-3:0] MAX_IDX   = (ADDR_WIDTH-2)'(DEPTH - 1);
    localparam logic [IDX_W-1:0]      LAST_WORD = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic                  oor_q, oor_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Full word index is kept so bits above IDX_W+2 still count as out of range.
    logic [ADDR_WIDTH-3:0] ridx, widx;
    logic                  r_mis, r_oor, w_ok;

    assign ridx  = A[ADDR_WIDTH-1:2];
    assign widx  = waddr[ADDR_WIDTH-1:2];
    assign r_mis = (A[1:0] != 2'b00);
    assign r_oor = (ridx > MAX_IDX);
    assign w_ok  = (waddr[1:0] == 2'b00) && (widx <= MAX_IDX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        mis_d     = mis_q;
        oor_d     = oor_q;
        mem_we    = 1'b0;
        mem_waddr = widx[IDX_W-1:0];
        mem_wdata = wdata;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = NOP;
                cnt_d     = cnt_q + 1'b1;
                rd_d      = NOP;
                valid_d   = 1'b0;
                mis_d     = 1'b0;
                oor_d     = 1'b0;
                if (cnt_q == LAST_WORD) state_d = ST_READY;
            end
            ST_READY: begin
                mem_we = we && w_ok;
                if (flush) begin
                    rd_d    = NOP;
                    valid_d = 1'b0;
                    mis_d   = 1'b0;
                    oor_d   = 1'b0;
                end else if (!stall) begin
                    rd_d    = NOP;
                    valid_d = 1'b0;
                    mis_d   = 1'b0;
                    oor_d   = 1'b0;
                    if (en) begin
                        if (r_mis) begin
                            mis_d = 1'b1;
                        end else if (r_oor) begin
                            oor_d = 1'b1;
                        end else begin
                            // Read sees the pre-write word: same-edge writes land after this sample.
                            rd_d    = mem[ridx[IDX_W-1:0]];
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_READY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT_CLEAR ? ST_CLEAR : ST_READY;
            cnt_q   <= '0;
            rd_q    <= NOP;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            oor_q   <= oor_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; the CLEAR sweep initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign RD           = rd_q;
    assign rd_valid     = valid_q;
    assign misaligned   = mis_q;
    assign out_of_range = oor_q;
    assign ready        = (state_q == ST_READY);

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: a reference memory model predicts each
// fetch result, which is queued at drive time and compared after the edge.
module tb_instr_mem_sync;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, en, stall, flush, we;
    logic [31:0] A, waddr, wdata;
    logic [31:0] RD, RD2;
    logic        rd_valid, misaligned, out_of_range, ready;
    logic        rd_valid2, misaligned2, out_of_range2, ready2;

    always #5 clk = ~clk;

    instr_mem_sync #(.INIT_CLEAR(1'b1)) dut (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .flush(flush), .A(A),
        .RD(RD), .rd_valid(rd_valid), .misaligned(misaligned),
        .out_of_range(out_of_range), .ready(ready),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    instr_mem_sync #(.INIT_CLEAR(1'b0)) dut_noclr (
        .clk(clk), .reset(reset), .en(en), .stall(stall), .flush(flush), .A(A),
        .RD(RD2), .rd_valid(rd_valid2), .misaligned(misaligned2),
        .out_of_range(out_of_range2), .ready(ready2),
        .we(we), .waddr(waddr), .wdata(wdata)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        v;
        logic        m;
        logic        o;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_exp;
    logic [31:0] mem_m [DEPTH];
    int          checks   = 0;
    int          failures = 0;

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;
        last_exp = '{rd: NOP, v: 1'b0, m: 1'b0, o: 1'b0};
    endtask

    // One clock of stimulus: predict, queue, advance, then pop and compare at negedge.
    task automatic sb_step(input string name, input logic e, input logic [31:0] a,
                           input logic s, input logic f, input logic w,
                           input logic [31:0] wa, input logic [31:0] wd);
        exp_t x, got;
        en = e; A = a; stall = s; flush = f; we = w; waddr = wa; wdata = wd;
        if (f)                       x = '{rd: NOP, v: 1'b0, m: 1'b0, o: 1'b0};
        else if (s)                  x = last_exp;
        else if (!e)                 x = '{rd: NOP, v: 1'b0, m: 1'b0, o: 1'b0};
        else if (a[1:0] != 2'b00)    x = '{rd: NOP, v: 1'b0, m: 1'b1, o: 1'b0};
        else if (a[31:2] >= DEPTH)   x = '{rd: NOP, v: 1'b0, m: 1'b0, o: 1'b1};
        else                         x = '{rd: mem_m[a[7:2]], v: 1'b1, m: 1'b0, o: 1'b0};
        sb_q.push_back(x);
        last_exp = x;
        if (w && wa[1:0] == 2'b00 && wa[31:2] < DEPTH) mem_m[wa[7:2]] = wd;
        @(posedge clk);
        @(negedge clk);
        x   = sb_q.pop_front();
        got = '{rd: RD, v: rd_valid, m: misaligned, o: out_of_range};
        checks++;
        if (got !== x) begin
            failures++;
            $display("FAIL %s: RD=%h v=%b mis=%b oor=%b, required RD=%h v=%b mis=%b oor=%b",
                     name, got.rd, got.v, got.m, got.o, x.rd, x.v, x.m, x.o);
        end
        en = 1'b0; stall = 1'b0; flush = 1'b0; we = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [31:0] a);
        sb_step(name, 1'b1, a, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic write(input logic [31:0] wa, input logic [31:0] wd);
        sb_step("write_idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, wa, wd);
    endtask

    // Releases reset at a negedge and counts edges until ready rises.
    task automatic wait_sweep(input string name);
        int n = 0;
        reset = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_at_release: ready=%b, required 0", name, ready);
        end
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if (ready2 !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_noclear_ready: ready=%b after first edge, required 1", name, ready2);
                end
            end
        end
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL %s_sweep_len: ready rose after %0d edges, required %0d", name, n, DEPTH);
        end
        model_clear();
    endtask

    task automatic test_reset();
        en = 1'b0; stall = 1'b0; flush = 1'b0; we = 1'b0;
        A = '0; waddr = '0; wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({RD, rd_valid, misaligned, out_of_range, ready} !== {NOP, 4'b0000}) begin
            failures++;
            $display("FAIL reset_values: RD=%h v=%b mis=%b oor=%b rdy=%b, required RD=%h and all flags 0",
                     RD, rd_valid, misaligned, out_of_range, ready, NOP);
        end
        wait_sweep("init");
    endtask

    task automatic test_clear_fetch();
        fetch("clear_0x00", 32'h00);
        fetch("clear_0x04", 32'h04);
        fetch("clear_0xfc", 32'hFC);
    endtask

    task automatic test_write_read();
        write(32'h00, 32'h00a00293);
        write(32'h20, 32'h01c30333);
        fetch("wr_0x20", 32'h20);
        fetch("wr_0x00", 32'h00);
        fetch("wr_0x24_untouched", 32'h24);
    endtask

    task automatic test_invalid();
        fetch("misaligned_0x22", 32'h22);
        fetch("misaligned_0x01", 32'h01);
        fetch("oor_0x100", 32'h100);
        fetch("oor_high_bits", 32'h8000_0000);
        write(32'h100, 32'hBAD0_0001);
        write(32'h002, 32'hBAD0_0002);
        fetch("dropped_write_0x00", 32'h00);
        fetch("last_word_0xfc", 32'hFC);
    endtask

    task automatic test_stall_flush();
        fetch("stall_pre", 32'h20);
        for (int i = 0; i < 3; i++)
            sb_step("stall_hold", 1'b1, 32'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        sb_step("stall_flush", 1'b1, 32'h00, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        fetch("stall_oor_pre", 32'h104);
        sb_step("stall_hold_flag", 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        sb_step("flush_write", 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h10, 32'h12345678);
        fetch("flush_write_visible", 32'h10);
        sb_step("en_low", 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        sb_step("raw_old", 1'b1, 32'h08, 1'b0, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF);
        fetch("raw_new", 32'h08);
        fetch("b2b_0x00", 32'h00);
        fetch("b2b_0x20", 32'h20);
        fetch("b2b_0x08", 32'h08);
    endtask

    task automatic test_reset_midsweep();
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({RD, rd_valid, ready} !== {NOP, 2'b00}) begin
            failures++;
            $display("FAIL async_reset_ready: RD=%h v=%b rdy=%b, required RD=%h v=0 rdy=0",
                     RD, rd_valid, ready, NOP);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({RD, rd_valid, misaligned, out_of_range, ready} !== {NOP, 4'b0000}) begin
            failures++;
            $display("FAIL midsweep_reset: RD=%h v=%b mis=%b oor=%b rdy=%b, required RD=%h and all flags 0",
                     RD, rd_valid, misaligned, out_of_range, ready, NOP);
        end
        @(negedge clk);
        wait_sweep("midsweep");
        fetch("swept_0x08", 32'h08);
        fetch("swept_0x00", 32'h00);
    endtask

    initial begin
        test_reset();
        test_clear_fetch();
        test_write_read();
        test_invalid();
        test_stall_flush();
        test_back_to_back();
        test_reset_midsweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined RISC-V core; replaces the fixed 64-word combinational ROM in the IF stage.
- Adds a registered read port with 1-cycle latency and stall/flush control for the IF/ID boundary.
- Adds a word-write loader port, a post-reset NOP-clear sweep, and misaligned/out-of-range detection; every invalid fetch returns a NOP.

Parameters:
ADDR_WIDTH, 32, byte-address width of A and waddr
DATA_WIDTH, 32, instruction word width
DEPTH, 64, number of words; power of two, >= 2
NOP, 32'h00000013, word returned on flush, invalid fetch or reset (addi x0,x0,0)
INIT_CLEAR, 1, 1 = sweep all words to NOP after reset; 0 = skip the sweep and go straight to READY

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  fetch request
stall  in  1  hold current output
flush  in  1  replace next output with NOP
A  in  ADDR_WIDTH  fetch byte address
RD  out  DATA_WIDTH  registered instruction
rd_valid  out  1  RD holds a real fetched instruction
misaligned  out  1  registered flag: last fetch had A[1:0]!=0
out_of_range  out  1  registered flag: last fetch word index >= DEPTH
ready  out  1  memory accepts fetches and writes
we  in  1  loader write enable
waddr  in  ADDR_WIDTH  loader byte address
wdata  in  DATA_WIDTH  loader data

Behaviour:
- Word index = A[ADDR_WIDTH-1:2]; likewise waddr[ADDR_WIDTH-1:2] for writes. IDX_W = clog2(DEPTH).
- Reset (async, any time, including mid-sweep):
  - RD=NOP; rd_valid=0; misaligned=0; out_of_range=0.
  - Sweep counter=0.
  - State=CLEAR if INIT_CLEAR else READY; ready=0 while in CLEAR.
  - Memory contents are not reset directly; the CLEAR sweep rewrites them.
- State CLEAR:
  - Write NOP to mem[cnt] each cycle; cnt++.
  - When cnt==DEPTH-1 is written, go to READY on the next edge. CLEAR lasts exactly DEPTH cycles.
  - en, stall, flush and we are ignored; RD stays NOP; rd_valid stays 0.
- State READY: ready=1. Per rising edge, priority is flush > stall > en:
  - flush=1: RD<=NOP, rd_valid<=0, both flags<=0.
  - stall=1 (no flush): RD, rd_valid and both flags hold.
  - en=1 with A[1:0]!=0: RD<=NOP, rd_valid<=0, misaligned<=1, out_of_range<=0.
  - en=1 with index>=DEPTH (aligned): RD<=NOP, rd_valid<=0, out_of_range<=1, misaligned<=0.
  - en=1, aligned and in range: RD<=mem[index], rd_valid<=1, both flags<=0.
  - en=0: RD<=NOP, rd_valid<=0, both flags<=0.
- Read latency: address presented at edge N yields RD after edge N+1 (1 cycle).
- Writes (READY only):
  - we=1 with waddr aligned and in range: mem[windex]<=wdata at the edge.
  - Misaligned or out-of-range writes are dropped silently. Stall and flush do not block writes.
- Same-cycle read and write to the same index: read-first (RD gets the old word); the new word is visible on the next fetch.
- Only the word-index bits that matter are decoded; upper bits above IDX_W+2 participate in the out-of-range check.
- Memory is a plain array, so it can be preloaded from a file by the bench when INIT_CLEAR=0.

Test Plan:
- Reset, INIT_CLEAR=1, DEPTH=64 -> ready=0 for exactly 64 cycles, then 1; fetch A=0x0,0x4,0xFC -> RD=0x00000013 on each, rd_valid=1.
- Write 0x00a00293 @0x0 and 0x01c30333 @0x20; fetch A=0x20 at edge N -> RD=0x01c30333, rd_valid=1 after edge N+1; fetch A=0x0 -> 0x00a00293.
- Fetch A=0x22 -> RD=NOP, misaligned=1, rd_valid=0; fetch A=0x100 (index 64) -> RD=NOP, out_of_range=1; write to 0x100 -> fetch 0x0 unchanged.
- Fetch 0x20 (RD=0x01c30333), then stall=1 for 3 cycles with A=0x0 -> RD holds 0x01c30333; stall and flush together -> RD=NOP, rd_valid=0.
- Same edge: we=1 waddr=0x8 wdata=0xDEADBEEF and fetch A=0x8 -> RD=old word (NOP); refetch 0x8 -> 0xDEADBEEF.
- Assert reset at sweep cycle 30 -> outputs return to reset values immediately; ready stays 0 for a fresh 64 cycles; INIT_CLEAR=0 build -> ready=1 on the first edge after reset release.
